// File: rtl/spi_arb_pkg.sv
// Shared constants for the SPI transaction arbiter: field widths, legal
// command codes and FSM state encodings.
package spi_arb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int CMD_W  = 8;

   localparam logic [CMD_W-1:0] CMD_WRITE = 8'h02;
   localparam logic [CMD_W-1:0] CMD_READ  = 8'h0B;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   function automatic logic cmd_is_legal(input logic [CMD_W-1:0] cmd);
      return (cmd == CMD_WRITE) || (cmd == CMD_READ);
   endfunction

endpackage

// File: rtl/spi_arb_rr_arbiter.sv
// Combinational round-robin pick: the first valid requester after the
// last-granted index wins, wrapping around.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [IDX_W-1:0]   last,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   // Walk offsets from farthest to nearest so the nearest valid index is the final assignment.
   always_comb begin
      int cand;
      cand = 0;
      idx  = '0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         cand = (int'(last) + off) % NUM_REQ;
         if (valid[cand]) begin
            idx = IDX_W'(cand);
         end
      end
      any   = |valid;
      grant = NUM_REQ'(any) << idx;
   end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Round-robin scheduler sharing one SPI transaction engine between NUM_REQ
// requesters. Define SPI_ARB_TIMEOUT_EN to enable the engine watchdog/abort.
module spi_txn_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   input  logic [NUM_REQ*CMD_W-1:0]  req_cmd_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]        rsp_valid_o,
   output logic [DATA_W-1:0]         rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      eng_valid_o,
   input  logic                      eng_ready_i,
   output logic [CMD_W-1:0]          eng_cmd_o,
   output logic [ADDR_W-1:0]         eng_addr_o,
   output logic [DATA_W-1:0]         eng_wdata_o,
   input  logic                      eng_done_i,
   input  logic [DATA_W-1:0]         eng_rdata_i,
   output logic                      eng_abort_o,
   output logic                      busy_o
);

   localparam int IDX_W = $clog2(NUM_REQ);

   logic [1:0]         state;
   logic [IDX_W-1:0]   last_grant;
   logic [IDX_W-1:0]   cur_grant;
   logic [NUM_REQ-1:0] pick_grant;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic [CMD_W-1:0]   sel_cmd;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;
   logic               expired;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .valid (req_valid_i),
      .last  (last_grant),
      .grant (pick_grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign sel_cmd   = req_cmd_i[int'(pick_idx)*CMD_W +: CMD_W];
   assign sel_addr  = req_addr_i[int'(pick_idx)*ADDR_W +: ADDR_W];
   assign sel_wdata = req_wdata_i[int'(pick_idx)*DATA_W +: DATA_W];

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] tmo_cnt;

   // A done pulse in WAIT on the expiry cycle is a normal completion, not a timeout.
   assign expired = ((state == ST_ISSUE) || ((state == ST_WAIT) && !eng_done_i)) &&
                    (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tmo_cnt <= '0;
      end else if ((state == ST_ISSUE) || (state == ST_WAIT)) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
         tmo_cnt <= '0;
      end
   end
`else
   assign expired = 1'b0;
`endif

   assign eng_abort_o = expired;
   assign eng_valid_o = (state == ST_ISSUE);
   assign busy_o      = (state != ST_IDLE);
   assign req_ready_o = (state == ST_IDLE) ? pick_grant : '0;
   assign rsp_valid_o = (state == ST_RESP) ? (NUM_REQ'(1) << cur_grant) : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= ST_IDLE;
         last_grant  <= IDX_W'(NUM_REQ - 1);
         cur_grant   <= '0;
         eng_cmd_o   <= '0;
         eng_addr_o  <= '0;
         eng_wdata_o <= '0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  cur_grant   <= pick_idx;
                  eng_cmd_o   <= sel_cmd;
                  eng_addr_o  <= sel_addr;
                  eng_wdata_o <= sel_wdata;
                  if (cmd_is_legal(sel_cmd)) begin
                     state <= ST_ISSUE;
                  end else begin
                     state       <= ST_RESP;
                     rsp_err_o   <= 1'b1;
                     rsp_rdata_o <= '0;
                  end
               end
            end
            ST_ISSUE: begin
               if (expired) begin
                  state       <= ST_RESP;
                  rsp_err_o   <= 1'b1;
                  rsp_rdata_o <= '0;
               end else if (eng_ready_i) begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (eng_done_i) begin
                  state       <= ST_RESP;
                  rsp_err_o   <= 1'b0;
                  rsp_rdata_o <= (eng_cmd_o == CMD_READ) ? eng_rdata_i : '0;
               end else if (expired) begin
                  state       <= ST_RESP;
                  rsp_err_o   <= 1'b1;
                  rsp_rdata_o <= '0;
               end
            end
            ST_RESP: begin
               last_grant <= cur_grant;
               state      <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed self-checking bench for spi_txn_arbiter with two requesters and a
// short timeout; the timeout scenario is built when SPI_ARB_TIMEOUT_EN is set.
module tb_spi_txn_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [15:0] req_cmd;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        eng_valid;
   logic        eng_ready;
   logic [7:0]  eng_cmd;
   logic [31:0] eng_addr;
   logic [31:0] eng_wdata;
   logic        eng_done;
   logic [31:0] eng_rdata;
   logic        eng_abort;
   logic        busy;

   int tests_run    = 0;
   int tests_failed = 0;

   spi_txn_arbiter #(
      .NUM_REQ        (2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_cmd_i   (req_cmd),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .eng_valid_o (eng_valid),
      .eng_ready_i (eng_ready),
      .eng_cmd_o   (eng_cmd),
      .eng_addr_o  (eng_addr),
      .eng_wdata_o (eng_wdata),
      .eng_done_i  (eng_done),
      .eng_rdata_i (eng_rdata),
      .eng_abort_o (eng_abort),
      .busy_o      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Legal transaction with an engine that accepts and completes as fast as allowed.
   task automatic txn(input string tag, input logic [1:0] exp_grant, input logic [7:0] exp_cmd,
                      input logic [31:0] exp_addr, input logic [31:0] eng_data,
                      input logic [31:0] exp_rdata, input logic [1:0] hold_valid);
      #1;
      check({tag, "_ready"}, 32'(req_ready), 32'(exp_grant));
      tick();
      req_valid = hold_valid;
      eng_ready = 1'b1;
      #1;
      check({tag, "_eng_valid"}, 32'(eng_valid), 32'd1);
      check({tag, "_eng_cmd"}, 32'(eng_cmd), 32'(exp_cmd));
      check({tag, "_eng_addr"}, eng_addr, exp_addr);
      tick();
      eng_ready = 1'b0;
      eng_done  = 1'b1;
      eng_rdata = eng_data;
      #1;
      check({tag, "_no_early_rsp"}, 32'(rsp_valid), 32'd0);
      tick();
      eng_done = 1'b0;
      #1;
      check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'(exp_grant));
      check({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
      check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
      check({tag, "_no_ready_in_resp"}, 32'(req_ready), 32'd0);
      tick();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic flag;
      rst_n     = 1'b1;
      req_valid = 2'b00;
      req_cmd   = '0;
      req_addr  = '0;
      req_wdata = '0;
      eng_ready = 1'b0;
      eng_done  = 1'b0;
      eng_rdata = '0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_eng_valid", 32'(eng_valid), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_eng_abort", 32'(eng_abort), 32'd0);
      check("rst_rsp_err", 32'(rsp_err), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      tick();

      // Single write from requester 0.
      req_cmd   = {8'h0B, 8'h02};
      req_addr  = {32'h0000_1111, 32'h0000_0080};
      req_wdata = {32'h0000_2222, 32'h0000_0064};
      req_valid = 2'b01;
      txn("wr", 2'b01, 8'h02, 32'h80, 32'h1234_5678, 32'h0, 2'b00);
      check("wr_eng_wdata", eng_wdata, 32'h64);
      check("wr_idle", 32'(busy), 32'd0);

      // Single read from requester 1.
      req_cmd   = {8'h0B, 8'h02};
      req_addr  = {32'h0000_0064, 32'h0000_0080};
      req_valid = 2'b10;
      txn("rd", 2'b10, 8'h0B, 32'h64, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00);

      // Both requesters continuously valid: grants alternate starting at 0.
      req_cmd   = {8'h0B, 8'h0B};
      req_addr  = {32'h0000_0200, 32'h0000_0100};
      req_valid = 2'b11;
      txn("fair0", 2'b01, 8'h0B, 32'h100, 32'h1111_0000, 32'h1111_0000, 2'b11);
      txn("fair1", 2'b10, 8'h0B, 32'h200, 32'h2222_0000, 32'h2222_0000, 2'b11);
      txn("fair2", 2'b01, 8'h0B, 32'h100, 32'h3333_0000, 32'h3333_0000, 2'b11);
      txn("fair3", 2'b10, 8'h0B, 32'h200, 32'h4444_0000, 32'h4444_0000, 2'b00);

      // Illegal command is answered one cycle after accept without the engine.
      req_cmd   = {8'h0B, 8'h05};
      req_addr  = {32'h0000_0200, 32'h0000_0300};
      req_valid = 2'b01;
      #1;
      check("ill_ready", 32'(req_ready), 32'd1);
      tick();
      req_valid = 2'b00;
      #1;
      check("ill_eng_valid", 32'(eng_valid), 32'd0);
      check("ill_rsp_valid", 32'(rsp_valid), 32'd1);
      check("ill_rsp_err", 32'(rsp_err), 32'd1);
      check("ill_rsp_rdata", rsp_rdata, 32'd0);
      tick();
      check("ill_rsp_once", 32'(rsp_valid), 32'd0);
      check("ill_idle", 32'(busy), 32'd0);

      // Reset while waiting on the engine; pointer must return to requester 0.
      req_cmd   = {8'h0B, 8'h02};
      req_addr  = {32'h0000_0400, 32'h0000_0000};
      req_valid = 2'b10;
      #1;
      check("rstw_ready", 32'(req_ready), 32'd2);
      tick();
      req_valid = 2'b00;
      eng_ready = 1'b1;
      tick();
      eng_ready = 1'b0;
      #1;
      check("rstw_in_wait", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rstw_eng_valid", 32'(eng_valid), 32'd0);
      check("rstw_busy", 32'(busy), 32'd0);
      check("rstw_rsp_valid", 32'(rsp_valid), 32'd0);
      tick();
      @(negedge clk) rst_n = 1'b1;
      tick();
      check("rstw_no_rsp", 32'(rsp_valid), 32'd0);
      req_cmd   = {8'h0B, 8'h0B};
      req_addr  = {32'h0000_0600, 32'h0000_0500};
      req_valid = 2'b11;
      txn("post_rst", 2'b01, 8'h0B, 32'h500, 32'h0000_AAAA, 32'h0000_AAAA, 2'b00);

      // Engine that stalls: write from requester 1.
      req_cmd   = {8'h02, 8'h0B};
      req_addr  = {32'h0000_0700, 32'h0000_0500};
      req_wdata = {32'h0000_0055, 32'h0000_0000};
      req_valid = 2'b10;
      #1;
      check("stall_ready", 32'(req_ready), 32'd2);
      tick();
      req_valid = 2'b00;
      flag = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      eng_ready = 1'b1;
      #1;
      check("tmo_eng_valid", 32'(eng_valid), 32'd1);
      tick();
      eng_ready = 1'b0;
      for (int k = 2; k < 16; k++) begin
         if (eng_abort !== 1'b0 || rsp_valid !== 2'b00) flag = 1'b1;
         tick();
      end
      check("tmo_no_early_abort", 32'(flag), 32'd0);
      check("tmo_abort", 32'(eng_abort), 32'd1);
      check("tmo_abort_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
      check("tmo_rsp_valid", 32'(rsp_valid), 32'd2);
      check("tmo_rsp_err", 32'(rsp_err), 32'd1);
      check("tmo_rsp_rdata", rsp_rdata, 32'd0);
      check("tmo_abort_once", 32'(eng_abort), 32'd0);
`else
      #1;
      check("hold_issue", 32'(eng_valid), 32'd1);
      eng_done = 1'b1;
      tick();
      eng_done = 1'b0;
      #1;
      check("hold_done_ignored", 32'(eng_valid), 32'd1);
      check("hold_no_rsp", 32'(rsp_valid), 32'd0);
      eng_ready = 1'b1;
      tick();
      eng_ready = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (eng_abort !== 1'b0 || rsp_valid !== 2'b00 || busy !== 1'b1) flag = 1'b1;
         tick();
      end
      check("hold_wait_forever", 32'(flag), 32'd0);
      eng_done  = 1'b1;
      eng_rdata = 32'h0000_0099;
      tick();
      eng_done = 1'b0;
      #1;
      check("hold_rsp_valid", 32'(rsp_valid), 32'd2);
      check("hold_rsp_err", 32'(rsp_err), 32'd0);
      check("hold_rsp_rdata", rsp_rdata, 32'd0);
`endif
      tick();
      check("final_idle", 32'(busy), 32'd0);
      check("final_rdata_held", rsp_rdata, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
